// File: rtl/kl_mem_pkg.sv
// Shared memory-subsystem constants and types for the RAM-backed FIFO.
package kl_mem_pkg;

  localparam int KL_DATA_W = 16;
  localparam int KL_ADDR_W = 8;
  localparam int KL_DEPTH  = 2 ** KL_ADDR_W;

  typedef logic [KL_DATA_W-1:0] word_t;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry output stage: an output register plus one skid register that
// absorbs a RAM read returning while the consumer is stalled.
module fifo_skid2
  import kl_mem_pkg::*;
#(
  parameter int DATA_W = KL_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              skid_valid_o
);

  logic              out_v_q, out_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              take_s;

  assign take_s       = out_v_q & out_ready_i;
  assign out_valid_o  = out_v_q;
  assign out_data_o   = out_q;
  assign skid_valid_o = skid_v_q;

  // Next-state for the out/skid pair; the skid always drains into out first.
  always_comb begin
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    out_d    = out_q;
    skid_d   = skid_q;
    if (flush_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (take_s) begin
        out_d   = skid_q;
        out_v_d = 1'b1;
        if (in_valid_i) begin
          skid_d   = in_data_i;
          skid_v_d = 1'b1;
        end else begin
          skid_v_d = 1'b0;
        end
      end else begin
        // Upstream credit accounting guarantees no arrival here.
        skid_v_d = 1'b1;
      end
    end else if (!out_v_q || take_s) begin
      if (in_valid_i) begin
        out_d   = in_data_i;
        out_v_d = 1'b1;
      end else begin
        out_v_d = 1'b0;
      end
    end else begin
      if (in_valid_i) begin
        skid_d   = in_data_i;
        skid_v_d = 1'b1;
      end else begin
        skid_v_d = 1'b0;
      end
    end
  end

  // Output and skid registers; data words hold their value when emptied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_q    <= {DATA_W{1'b0}};
      skid_q   <= {DATA_W{1'b0}};
    end else begin
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller over an external single-clock dual-port RAM.
// Port A writes at wr_ptr, port B reads at rd_ptr; a 2-entry output stage
// hides the RAM's registered read latency so pops run at full rate.
module dpram_fifo_ctrl
  import kl_mem_pkg::*;
#(
  parameter int DATA_W = KL_DATA_W,
  parameter int ADDR_W = KL_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W+1:0] count,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_data_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  // Pointer distance that means the RAM is completely full.
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W+1:0] count_q, count_d;
  logic [ADDR_W:0]   ram_cnt_s;
  logic [1:0]        credit_s;
  logic              out_v_s, skid_v_s;
  logic              push_fire_s, pop_fire_s, issue_s;

  // ram_cnt only sees writes whose edge has passed, so a read never
  // targets a word that is being written in the same cycle.
  assign ram_cnt_s   = wr_ptr_q - rd_ptr_q;
  assign push_ready  = (ram_cnt_s != FULL_CNT);
  assign push_fire_s = push_valid & push_ready & ~flush;
  assign pop_fire_s  = out_v_s & pop_ready;
  assign credit_s    = {1'b0, out_v_s} + {1'b0, skid_v_s} + {1'b0, rd_pend_q};
  // Never more than two words committed to the output stage.
  assign issue_s     = ~flush & (ram_cnt_s != PTR_ZERO) &
                       ((credit_s - {1'b0, pop_fire_s}) < 2'd2);

  assign pop_valid  = out_v_s;
  assign count      = count_q;
  assign ram_addr_a = wr_ptr_q[ADDR_W-1:0];
  assign ram_data_a = push_data;
  assign ram_we_a   = push_fire_s;
  assign ram_addr_b = rd_ptr_q[ADDR_W-1:0];
  assign ram_data_b = {DATA_W{1'b0}};
  assign ram_we_b   = 1'b0;

  // Pointer, pending-read and occupancy next-state; flush wins over traffic.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_pend_d = 1'b0;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d  = PTR_ZERO;
      rd_ptr_d  = PTR_ZERO;
      rd_pend_d = 1'b0;
      count_d   = {(ADDR_W+2){1'b0}};
    end else begin
      if (push_fire_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (issue_s) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_pend_d = 1'b1;
      end else begin
        rd_ptr_d  = rd_ptr_q;
        rd_pend_d = 1'b0;
      end
      // Issuing a read only moves a word between stages, so the total
      // changes by pushes minus pops.
      count_d = {1'b0, ram_cnt_s} + {{ADDR_W{1'b0}}, credit_s}
              + {{(ADDR_W+1){1'b0}}, push_fire_s}
              - {{(ADDR_W+1){1'b0}}, pop_fire_s};
    end
  end

  // Pointer and occupancy registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      rd_pend_q <= 1'b0;
      count_q   <= {(ADDR_W+2){1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
    end
  end

  fifo_skid2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (rd_pend_q & ~flush),
    .in_data_i   (ram_q_b),
    .out_valid_o (out_v_s),
    .out_ready_i (pop_ready),
    .out_data_o  (pop_data),
    .skid_valid_o(skid_v_s)
  );

endmodule
